sliding_window_gen: RTL and testbench
=====================================

Name: sliding_window_gen

Overview:
- Parametrised successor of the fixed 3x3 line-buffer window generator; feeds Sobel and future KxK filter stages.
- Takes a raster pixel stream over a valid/ready handshake and emits one centred KxK window per pixel over a valid/ready handshake.
- Generates its own row/column counters; needs no external counts.
- Border mode (replicate or zero) is selectable. Row-end and frame-end padding is generated internally, so exactly IMG_W*IMG_H windows come out per frame.

Parameters:
- DATA_W, 8: pixel width in bits.
- IMG_W, 128: pixels per row, >= K.
- IMG_H, 128: rows per frame, >= K.
- K, 3: window size; odd, 3..7. R = (K-1)/2.
- BORDER, 0: 0 = replicate nearest edge pixel; 1 = zero padding.

Ports:
- clk  in  1  clock.
- xrst  in  1  reset; asynchronous, active-high (1 = reset).
- s_valid  in  1  input pixel valid.
- s_ready  out  1  block accepts the input pixel this cycle.
- s_data  in  DATA_W  input pixel, raster order.
- s_sof  in  1  marks the first pixel of a frame; sampled with s_valid&&s_ready.
- m_valid  out  1  window valid.
- m_ready  in  1  downstream accepts the window.
- m_window  out  K*K*DATA_W  element (a,b) at bits [(a*K+b)*DATA_W +: DATA_W]; a = row top→bottom, b = column left→right; centre at a=b=R.
- m_sof  out  1  first window of the frame (centre 0,0).
- m_eol  out  1  last window of a row.
- m_eof  out  1  last window of the frame.

Behaviour:
- Step grid:
  - Each frame is processed as (IMG_H+R) x (IMG_W+R) steps.
  - A step is either an accepted pixel or an internally generated pad slot.
  - Pad slots are columns j >= IMG_W (row drain) and rows i >= IMG_H (frame flush).
  - At step (i,j) with i>=R and j>=R, the window centred at (i-R, j-R) is emitted. No window is emitted otherwise.
- Border handling:
  - Replicate: off-image rows/columns take the value of the nearest in-image pixel.
  - Zero: off-image rows/columns are 0.
  - Applies on all four edges.
- States:
  - IDLE: s_ready=1; waits for s_valid&&s_sof.
  - RUN: accepts pixels for columns 0..IMG_W-1.
  - DRAIN: R pad steps at row end; s_ready=0.
  - FLUSH: R rows of IMG_W+R pad steps after the last input row; s_ready=0.
  - Transitions:
    - RUN→DRAIN after column IMG_W-1.
    - DRAIN→RUN when rows remain.
    - DRAIN→FLUSH after row IMG_H-1.
    - FLUSH→IDLE after the last step.
- Step advance: a step executes only when (!m_valid || m_ready). In RUN it also requires s_valid. s_ready = (state is IDLE or RUN) && (!m_valid || m_ready).
- Latency: a window appears on m_* the cycle after the step that completes it. Sustained throughput is one step per cycle.
- Back-pressure: while m_valid && !m_ready, m_window and all flags hold stable and no step executes.
- Line storage:
  - K-1 line memories of IMG_W x DATA_W, synchronous read.
  - Read address is prefetched one column ahead, wrapping IMG_W-1→0.
  - Column-shift registers: K x K.
- s_sof received while in RUN, DRAIN or FLUSH: abort the current frame.
  - Discard pending windows; clear m_valid.
  - Treat that pixel as (0,0) of a new frame.
  - Line memory contents need not be cleared; top-border logic must not read stale rows.
- s_sof missing in IDLE: pixels are accepted (s_ready=1) and dropped.
- Reset:
  - Any cycle, asynchronous. State→IDLE; all counters 0.
  - m_valid, m_sof, m_eol, m_eof = 0; m_window = 0; s_ready = 0 while xrst=1.
  - Line memories are not reset.
- Width rules:
  - Column counter is $clog2(IMG_W+R) bits; row counter is $clog2(IMG_H+R) bits. No arithmetic wrap inside a frame.

Decomposition:
- Shared package window_pkg:
  - BORDER_REPLICATE=0, BORDER_ZERO=1.
  - State enum {IDLE, RUN, DRAIN, FLUSH}.
  - Counter-width helper functions.
- Sub-module line_mem: 1W1R synchronous-read RAM, parameters DEPTH and DATA_W. Instantiated K-1 times.

Test Plan (IMG_W=4, IMG_H=3, pixel = row*16+col unless noted):
- Reset: assert xrst mid-frame → next cycle m_valid=0 and s_ready=0; after release, s_ready=1 and a new frame with s_sof runs correctly.
- K=3, replicate, m_ready=1 → 12 windows, in this order:
  - First window (m_sof=1) appears the cycle after step 7 (4 pixels + 1 pad + 2 pixels). Rows: [0,0,1], [0,0,1], [16,16,17].
  - Last window (m_eof=1, m_eol=1): [18,19,19], [34,35,35], [34,35,35].
  - m_eol set on windows 4, 8 and 12.
- K=3, zero → first window [0,0,0], [0,0,1], [0,16,17]; last window [18,19,0], [34,35,0], [0,0,0].
- Back-pressure: m_ready 50% random, s_valid 70% random → window sequence bit-identical to the m_ready=1 run; m_window stable whenever m_valid && !m_ready.
- Abort: s_sof reasserted on pixel 6 → no window from the first frame appears after the abort; the following frame yields 12 correct windows.
- K=5, IMG_W=IMG_H=5, replicate → 25 windows; centre (2,2) window equals pixels rows 0..4 × cols 0..4 exactly.

Source files
------------

// File: rtl/window_pkg.sv
// Shared types and sizing helpers for the KxK sliding-window generator.
package window_pkg;

  localparam int BORDER_REPLICATE = 0;
  localparam int BORDER_ZERO      = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_mem.sv
// 1W1R line memory with registered read data; contents are never reset.
module line_mem
  import window_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 8,
  localparam int AW    = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sliding_window_gen.sv
// Raster pixel stream in, one centred KxK window per pixel out. Row drain and
// frame flush pad steps are generated internally; borders are replicate or zero.
module sliding_window_gen
  import window_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int K      = 3,
  parameter int BORDER = 0
) (
  input  logic                  clk,
  input  logic                  xrst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_sof,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [K*K*DATA_W-1:0] m_window,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof
);

  localparam int R  = (K - 1) / 2;
  localparam int CW = cnt_w(IMG_W + R);
  localparam int RW = cnt_w(IMG_H + R);
  localparam int AW = cnt_w(IMG_W);
  localparam bit ZERO_PAD = (BORDER == BORDER_ZERO);

  localparam logic [CW-1:0] COL_R       = CW'(R);
  localparam logic [CW-1:0] COL_W       = CW'(IMG_W);
  localparam logic [CW-1:0] COL_LAST_PX = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_LAST    = CW'(IMG_W + R - 1);
  localparam logic [RW-1:0] ROW_R       = RW'(R);
  localparam logic [RW-1:0] ROW_LAST_PX = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_LAST    = RW'(IMG_H + R - 1);

  typedef logic [K-1:0][DATA_W-1:0] col_t;   // one window column, [row]

  state_t                        state;
  logic [CW-1:0]                 col;
  logic [RW-1:0]                 row;
  logic [K-2:0][K-1:0][DATA_W-1:0] sh;       // last K-1 border-fixed columns

  logic          out_free, s_acc, start, step_en, pad_col, emit;
  logic [CW-1:0] sj;
  logic [RW-1:0] si;
  logic [DATA_W-1:0] cur;
  logic [K-2:0][DATA_W-1:0] lm_q, lm_wdata;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_waddr, mem_raddr;
  col_t          raw, vcol, newcol, top_v, bot_v, left_v;
  logic [K-1:0][K-1:0][DATA_W-1:0] wcol, win;
  logic [K*K*DATA_W-1:0] win_flat;
  logic          f_sof, f_eol, f_eof;

  assign out_free = !m_valid || m_ready;
  assign s_ready  = !xrst && (state == IDLE || state == RUN) && out_free;
  assign s_acc    = s_valid && s_ready;
  assign start    = s_acc && s_sof;

  // An accepted s_sof restarts the grid at (0,0) regardless of position.
  always_comb begin
    step_en = 1'b0;
    case (state)
      IDLE:         step_en = start;
      RUN:          step_en = s_acc;
      DRAIN, FLUSH: step_en = out_free;
      default:      step_en = 1'b0;
    endcase
  end

  assign si      = start ? '0 : row;
  assign sj      = start ? '0 : col;
  assign pad_col = (sj >= COL_W);
  assign cur     = (state == FLUSH) ? '0 : s_data;

  // Line memories chain rows: lm[0] holds row i-1, lm[k] holds row i-1-k.
  // Reads prefetch the next column so data is ready when that step executes.
  assign mem_we    = step_en && !pad_col;
  assign mem_re    = step_en && !pad_col;
  assign mem_waddr = AW'(sj);
  assign mem_raddr = (sj == COL_LAST_PX) ? '0 : AW'(sj + 1'b1);

  always_comb begin
    lm_wdata[0] = cur;
    for (int k = 1; k < K - 1; k++) lm_wdata[k] = lm_q[k-1];
  end

  for (genvar k = 0; k < K - 1; k++) begin : g_lm
    line_mem #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lm (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (lm_wdata[k]),
      .re    (mem_re),
      .raddr (mem_raddr),
      .rdata (lm_q[k])
    );
  end

  always_comb begin
    int ii, jj, r, c;
    ii = int'(si);
    jj = int'(sj);
    for (int a = 0; a < K - 1; a++) raw[a] = lm_q[K-2-a];
    raw[K-1] = cur;

    // Rows above row 0 never come from memory, so stale rows after an abort
    // are masked; rows past the last row use the last real row.
    top_v = '0;
    bot_v = '0;
    for (int s = 0; s < K; s++) begin
      if (s == K - 1 - ii)         top_v[0] = raw[s];
      if (s == IMG_H + K - 2 - ii) bot_v[0] = raw[s];
    end
    for (int a = 0; a < K; a++) begin
      r = ii - (K - 1) + a;
      if (r < 0)           vcol[a] = ZERO_PAD ? '0 : top_v[0];
      else if (r >= IMG_H) vcol[a] = ZERO_PAD ? '0 : bot_v[0];
      else                 vcol[a] = raw[a];
    end

    // Right edge: pad columns repeat the newest column (or zero).
    newcol = pad_col ? (ZERO_PAD ? '0 : col_t'(sh[K-2])) : vcol;
    for (int p = 0; p < K - 1; p++) wcol[p] = sh[p];
    wcol[K-1] = newcol;

    // Left edge: columns left of column 0 hold previous-row data.
    left_v = '0;
    for (int p = 0; p < K; p++)
      if (p == K - 1 - jj) left_v = wcol[p];
    for (int p = 0; p < K; p++) begin
      c = jj - (K - 1) + p;
      win[p] = (c < 0) ? (ZERO_PAD ? '0 : left_v) : wcol[p];
    end

    win_flat = '0;
    for (int a = 0; a < K; a++)
      for (int b = 0; b < K; b++)
        win_flat[(a*K+b)*DATA_W +: DATA_W] = win[b][a];
  end

  assign emit  = (si >= ROW_R) && (sj >= COL_R);
  assign f_sof = (si == ROW_R) && (sj == COL_R);
  assign f_eol = (sj == COL_LAST);
  assign f_eof = f_eol && (si == ROW_LAST);

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      state    <= IDLE;
      col      <= '0;
      row      <= '0;
      sh       <= '0;
      m_valid  <= 1'b0;
      m_sof    <= 1'b0;
      m_eol    <= 1'b0;
      m_eof    <= 1'b0;
      m_window <= '0;
    end else if (step_en) begin
      sh      <= wcol[K-1:1];
      m_valid <= emit;
      if (emit) begin
        m_window <= win_flat;
        m_sof    <= f_sof;
        m_eol    <= f_eol;
        m_eof    <= f_eof;
      end
      case (state)
        IDLE: begin
          state <= RUN;
          col   <= CW'(1);
          row   <= '0;
        end
        RUN: begin
          if (start) begin
            col <= CW'(1);
            row <= '0;
          end else begin
            col <= col + 1'b1;
            if (col == COL_LAST_PX) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (col == COL_LAST) begin
            col   <= '0;
            row   <= row + 1'b1;
            state <= (row == ROW_LAST_PX) ? FLUSH : RUN;
          end else begin
            col <= col + 1'b1;
          end
        end
        FLUSH: begin
          if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST) begin
              row   <= '0;
              state <= IDLE;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            col <= col + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end else if (out_free) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sliding_window_gen.sv
// Directed bench: 4x3 frames with K=3 (replicate and zero side by side) and a
// 5x5 frame with K=5; pixel value = row*16 + col (+ frame offset).
module tb_sliding_window_gen;

  logic        clk = 1'b0;
  logic        xrst;
  logic        s_valid, s_sof, m_ready;
  logic [7:0]  s_data;
  logic        s_ready_r, s_ready_z, m_valid_r, m_valid_z;
  logic [71:0] win_r, win_z;
  logic        sof_r, eol_r, eof_r, sof_z, eol_z, eof_z;

  logic         s_valid5, s_sof5, m_ready5, s_ready5, m_valid5;
  logic [7:0]   s_data5;
  logic [199:0] win5;
  logic         sof5, eol5, eof5;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sliding_window_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(3), .K(3), .BORDER(0)) u_rep (
    .clk(clk), .xrst(xrst), .s_valid(s_valid), .s_ready(s_ready_r), .s_data(s_data),
    .s_sof(s_sof), .m_valid(m_valid_r), .m_ready(m_ready), .m_window(win_r),
    .m_sof(sof_r), .m_eol(eol_r), .m_eof(eof_r));

  sliding_window_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(3), .K(3), .BORDER(1)) u_zero (
    .clk(clk), .xrst(xrst), .s_valid(s_valid), .s_ready(s_ready_z), .s_data(s_data),
    .s_sof(s_sof), .m_valid(m_valid_z), .m_ready(m_ready), .m_window(win_z),
    .m_sof(sof_z), .m_eol(eol_z), .m_eof(eof_z));

  sliding_window_gen #(.DATA_W(8), .IMG_W(5), .IMG_H(5), .K(5), .BORDER(0)) u_k5 (
    .clk(clk), .xrst(xrst), .s_valid(s_valid5), .s_ready(s_ready5), .s_data(s_data5),
    .s_sof(s_sof5), .m_valid(m_valid5), .m_ready(m_ready5), .m_window(win5),
    .m_sof(sof5), .m_eol(eol5), .m_eof(eof5));

  // Stimulus queue and captured windows for the K=3 pair.
  logic [7:0]  q_data[$];
  logic        q_sof[$];
  logic [71:0] cap_r[$], cap_z[$], ref_r[$];
  logic [5:0]  cap_f[$];
  int first_acc, first_cap, hold_bad, hold_seen, lock_bad;

  function automatic logic [199:0] model_win(input int kk, input int w, input int h,
                                             input int bz, input int off,
                                             input int cr, input int cc);
    logic [199:0] v;
    int r, c, p;
    v = '0;
    for (int a = 0; a < kk; a++)
      for (int b = 0; b < kk; b++) begin
        r = cr - (kk - 1) / 2 + a;
        c = cc - (kk - 1) / 2 + b;
        if ((r < 0 || r >= h || c < 0 || c >= w) && bz != 0) p = 0;
        else begin
          r = (r < 0) ? 0 : (r >= h) ? h - 1 : r;
          c = (c < 0) ? 0 : (c >= w) ? w - 1 : c;
          p = r * 16 + c + off;
        end
        v[(a*kk+b)*8 +: 8] = 8'(p);
      end
    return v;
  endfunction

  function automatic logic [71:0] pack9(input int a0, input int a1, input int a2,
                                        input int b0, input int b1, input int b2,
                                        input int c0, input int c1, input int c2);
    int e[9];
    logic [71:0] v;
    e = '{a0, a1, a2, b0, b1, b2, c0, c1, c2};
    for (int k = 0; k < 9; k++) v[k*8 +: 8] = 8'(e[k]);
    return v;
  endfunction

  task automatic push_frame(input int npix, input int off);
    for (int p = 0; p < npix; p++) begin
      q_data.push_back(8'((p / 4) * 16 + (p % 4) + off));
      q_sof.push_back(p == 0);
    end
  endtask

  // Drives the queued pixels into the K=3 pair and records transfers made
  // after the first pixel of this run has been accepted.
  task automatic drive_k3(input int vpct, input int rpct, input int exp_n,
                          input int tail_len, input int budget);
    logic [71:0] pw;
    logic [2:0]  pf;
    logic        phold, started;
    int tail;
    cap_r.delete(); cap_z.delete(); cap_f.delete();
    phold = 0; started = 0; tail = -1;
    first_acc = -1; first_cap = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      s_valid = (q_data.size() > 0) && (int'($urandom_range(99)) < vpct);
      s_data  = (q_data.size() > 0) ? q_data[0] : 8'h00;
      s_sof   = (q_data.size() > 0) ? q_sof[0] : 1'b0;
      m_ready = int'($urandom_range(99)) < rpct;
      #1;
      if (phold) begin
        hold_seen++;
        if (!m_valid_r || win_r !== pw || {sof_r, eol_r, eof_r} !== pf) hold_bad++;
      end
      if (s_ready_r !== s_ready_z || m_valid_r !== m_valid_z) lock_bad++;
      phold = m_valid_r && !m_ready;
      pw = win_r;
      pf = {sof_r, eol_r, eof_r};
      if (m_valid_r && m_ready && started) begin
        cap_r.push_back(win_r);
        cap_z.push_back(win_z);
        cap_f.push_back({sof_r, eol_r, eof_r, sof_z, eol_z, eof_z});
        if (first_cap < 0) first_cap = c;
      end
      if (s_valid && s_ready_r) begin
        if (!started) first_acc = c;
        started = 1;
        void'(q_data.pop_front());
        void'(q_sof.pop_front());
      end
      if (tail < 0 && q_data.size() == 0 && cap_r.size() >= exp_n) tail = c + tail_len;
      if (tail >= 0 && c >= tail) break;
    end
  endtask

  task automatic idle_k3();
    @(negedge clk);
    s_valid = 0; s_sof = 0; s_data = 0; m_ready = 1;
  endtask

  task automatic test_reset();
    xrst = 1;
    s_valid = 0; s_sof = 0; s_data = 0; m_ready = 1;
    s_valid5 = 0; s_sof5 = 0; s_data5 = 0; m_ready5 = 1;
    #2;
    n_vec++;
    if ({m_valid_r, s_ready_r, sof_r, eol_r, eof_r, m_valid_z, s_ready_z, m_valid5, s_ready5}
        !== 9'b0) begin
      n_err++; $display("FAIL reset_flags: got %b expected 0",
        {m_valid_r, s_ready_r, sof_r, eol_r, eof_r, m_valid_z, s_ready_z, m_valid5, s_ready5});
    end
    n_vec++;
    if (win_r !== 72'h0 || win_z !== 72'h0 || win5 !== 200'h0) begin
      n_err++; $display("FAIL reset_window: got %h expected 0", win_r);
    end
    @(negedge clk); @(negedge clk);
    xrst = 0;
    #1;
    n_vec++;
    if (s_ready_r !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %b expected 1", s_ready_r);
    end
    // Mid-frame reset with a window pending on the output.
    push_frame(7, 0);
    drive_k3(100, 100, 0, 0, 100);
    @(negedge clk);
    s_valid = 0;
    #1;
    n_vec++;
    if (m_valid_r !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_pending: got %b expected 1", m_valid_r);
    end
    xrst = 1;
    #1;
    n_vec++;
    if (m_valid_r !== 1'b0 || s_ready_r !== 1'b0 || win_r !== 72'h0) begin
      n_err++; $display("FAIL midframe_reset: got v=%b r=%b expected v=0 r=0", m_valid_r, s_ready_r);
    end
    @(negedge clk);
    xrst = 0;
    #1;
    n_vec++;
    if (s_ready_r !== 1'b1 || m_valid_r !== 1'b0) begin
      n_err++; $display("FAIL after_reset_ready: got r=%b v=%b expected r=1 v=0", s_ready_r, m_valid_r);
    end
  endtask

  task automatic test_replicate();
    logic [71:0] exp_first, exp_last;
    logic [5:0]  ef;
    exp_first = pack9(0, 0, 1, 0, 0, 1, 16, 16, 17);
    exp_last  = pack9(18, 19, 19, 34, 35, 35, 34, 35, 35);
    push_frame(12, 0);
    drive_k3(100, 100, 12, 10, 200);
    idle_k3();
    n_vec++;
    if (cap_r.size() != 12) begin
      n_err++; $display("FAIL rep_count: got %0d expected 12", cap_r.size());
    end
    n_vec++;
    if (first_cap - first_acc != 7) begin
      n_err++; $display("FAIL rep_latency: got %0d expected 7", first_cap - first_acc);
    end
    n_vec++;
    if ((cap_r.size() > 0 ? cap_r[0] : 72'hx) !== exp_first) begin
      n_err++; $display("FAIL rep_first: got %h expected %h", cap_r[0], exp_first);
    end
    n_vec++;
    if ((cap_r.size() > 11 ? cap_r[11] : 72'hx) !== exp_last) begin
      n_err++; $display("FAIL rep_last: got %h expected %h", cap_r[11], exp_last);
    end
    for (int n = 0; n < cap_r.size(); n++) begin
      ef = {n == 0, n == 3 || n == 7 || n == 11, n == 11, n == 0, n == 3 || n == 7 || n == 11, n == 11};
      n_vec++;
      if (cap_f[n] !== ef) begin
        n_err++; $display("FAIL rep_flags[%0d]: got %b expected %b", n, cap_f[n], ef);
      end
      n_vec++;
      if (cap_r[n] !== model_win(3, 4, 3, 0, 0, n / 4, n % 4)[71:0]) begin
        n_err++; $display("FAIL rep_win[%0d]: got %h expected %h", n, cap_r[n],
                          model_win(3, 4, 3, 0, 0, n / 4, n % 4)[71:0]);
      end
    end
    ref_r = cap_r;
  endtask

  task automatic test_zero();
    logic [71:0] exp_first, exp_last;
    exp_first = pack9(0, 0, 0, 0, 0, 1, 0, 16, 17);
    exp_last  = pack9(18, 19, 0, 34, 35, 0, 0, 0, 0);
    push_frame(12, 0);
    drive_k3(100, 100, 12, 10, 200);
    idle_k3();
    n_vec++;
    if (cap_z.size() != 12) begin
      n_err++; $display("FAIL zero_count: got %0d expected 12", cap_z.size());
    end
    n_vec++;
    if ((cap_z.size() > 0 ? cap_z[0] : 72'hx) !== exp_first) begin
      n_err++; $display("FAIL zero_first: got %h expected %h", cap_z[0], exp_first);
    end
    n_vec++;
    if ((cap_z.size() > 11 ? cap_z[11] : 72'hx) !== exp_last) begin
      n_err++; $display("FAIL zero_last: got %h expected %h", cap_z[11], exp_last);
    end
    for (int n = 0; n < cap_z.size(); n++) begin
      n_vec++;
      if (cap_z[n] !== model_win(3, 4, 3, 1, 0, n / 4, n % 4)[71:0]) begin
        n_err++; $display("FAIL zero_win[%0d]: got %h expected %h", n, cap_z[n],
                          model_win(3, 4, 3, 1, 0, n / 4, n % 4)[71:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    hold_bad = 0; hold_seen = 0; lock_bad = 0;
    push_frame(12, 0);
    drive_k3(70, 50, 12, 10, 2000);
    idle_k3();
    n_vec++;
    if (cap_r.size() != 12) begin
      n_err++; $display("FAIL bp_count: got %0d expected 12", cap_r.size());
    end
    for (int n = 0; n < cap_r.size(); n++) begin
      n_vec++;
      if (n >= ref_r.size() || cap_r[n] !== ref_r[n]) begin
        n_err++; $display("FAIL bp_seq[%0d]: got %h expected %h", n, cap_r[n],
                          model_win(3, 4, 3, 0, 0, n / 4, n % 4)[71:0]);
      end
      n_vec++;
      if (cap_z[n] !== model_win(3, 4, 3, 1, 0, n / 4, n % 4)[71:0]) begin
        n_err++; $display("FAIL bp_zero[%0d]: got %h expected %h", n, cap_z[n],
                          model_win(3, 4, 3, 1, 0, n / 4, n % 4)[71:0]);
      end
    end
    n_vec++;
    if (hold_seen == 0 || hold_bad != 0) begin
      n_err++; $display("FAIL bp_hold: got %0d unstable of %0d stalls, expected 0 unstable of >0",
                        hold_bad, hold_seen);
    end
    n_vec++;
    if (lock_bad != 0) begin
      n_err++; $display("FAIL bp_lockstep: got %0d diverging cycles expected 0", lock_bad);
    end
  endtask

  task automatic test_abort();
    push_frame(6, 0);
    drive_k3(100, 100, 0, 0, 100);
    push_frame(12, 100);
    drive_k3(100, 100, 12, 12, 300);
    idle_k3();
    n_vec++;
    if (cap_r.size() != 12) begin
      n_err++; $display("FAIL abort_count: got %0d expected 12", cap_r.size());
    end
    n_vec++;
    if ((cap_f.size() > 0 ? cap_f[0][5] : 1'bx) !== 1'b1) begin
      n_err++; $display("FAIL abort_first_sof: got %b expected 1", cap_f[0][5]);
    end
    for (int n = 0; n < cap_r.size(); n++) begin
      n_vec++;
      if (cap_r[n] !== model_win(3, 4, 3, 0, 100, n / 4, n % 4)[71:0] ||
          cap_z[n] !== model_win(3, 4, 3, 1, 100, n / 4, n % 4)[71:0]) begin
        n_err++; $display("FAIL abort_win[%0d]: got %h expected %h", n, cap_r[n],
                          model_win(3, 4, 3, 0, 100, n / 4, n % 4)[71:0]);
      end
    end
  endtask

  task automatic test_k5();
    logic [199:0] cw[$];
    logic [2:0]   cf[$];
    logic [199:0] centre;
    int p;
    p = 0;
    for (int a = 0; a < 5; a++)
      for (int b = 0; b < 5; b++) centre[(a*5+b)*8 +: 8] = 8'(a * 16 + b);
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      s_valid5 = (p < 25);
      s_data5  = 8'((p / 5) * 16 + (p % 5));
      s_sof5   = (p == 0);
      m_ready5 = 1;
      #1;
      if (m_valid5) begin
        cw.push_back(win5);
        cf.push_back({sof5, eol5, eof5});
      end
      if (s_valid5 && s_ready5) p++;
    end
    s_valid5 = 0;
    n_vec++;
    if (cw.size() != 25) begin
      n_err++; $display("FAIL k5_count: got %0d expected 25", cw.size());
    end
    n_vec++;
    if ((cw.size() > 12 ? cw[12] : 200'hx) !== centre) begin
      n_err++; $display("FAIL k5_centre: got %h expected %h", cw[12], centre);
    end
    n_vec++;
    if (cw.size() != 25 || cf[0] !== 3'b100 || cf[4] !== 3'b010 || cf[24] !== 3'b011) begin
      n_err++; $display("FAIL k5_flags: got %b %b %b expected 100 010 011", cf[0], cf[4], cf[24]);
    end
    for (int n = 0; n < cw.size(); n++) begin
      n_vec++;
      if (cw[n] !== model_win(5, 5, 5, 0, 0, n / 5, n % 5)) begin
        n_err++; $display("FAIL k5_win[%0d]: got %h expected %h", n, cw[n],
                          model_win(5, 5, 5, 0, 0, n / 5, n % 5));
      end
    end
  endtask

  initial begin
    test_reset();
    test_replicate();
    test_zero();
    test_backpressure();
    test_abort();
    test_k5();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
